dmem_responder: RTL

- Memory-side responder for the pipelined MIPS CPU data port.
- The CPU initiates load/store requests over a valid/ready handshake; this block accepts one request at a time, inserts programmable wait states, performs the word access with byte enables on an internal word array, and returns read data or completion status over a valid/ready response channel.
- Stands in place of the single-cycle combinational data memory, so the pipeline's stall logic can be exercised against a real multi-cycle memory.

---
 rtl/dmem_responder.sv | 133 +++++++++++++
 1 files changed

// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder for the CPU load/store port.
// It takes one request at a time, adds programmable wait states, then accesses a byte-enabled word array.
module dmem_responder #(
    parameter int DEPTH       = 256,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_we_i,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
    input  logic [3:0]  req_be_i,
    output logic        resp_valid_o,
    input  logic        resp_ready_i,
    output logic [31:0] resp_rdata_o,
    output logic        resp_err_o
);
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_ACCESS,
        S_RESP
    } state_e;

    state_e        state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [31:0]   rdata_q, rdata_d;
    logic          err_q, err_d;
    logic          ready_q;
    logic          we_q;
    logic [31:0]   addr_q;
    logic [31:0]   wdata_q;
    logic [3:0]    be_q;
    logic [31:0]   mem_q [DEPTH];

    logic          req_hs;
    logic          acc_err;
    logic          mem_wr;
    logic [IW-1:0] word_idx;

    // ready_q is only ever 1 in IDLE, so it doubles as the "accepting" qualifier.
    assign req_hs   = req_valid_i && ready_q;
    assign acc_err  = (addr_q[1:0] != 2'b00) || (addr_q[31:2] >= 30'(DEPTH));
    assign word_idx = addr_q[IW+1:2];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        mem_wr  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (req_hs) begin
                    if (WAIT_CYCLES == 0) begin
                        state_d = S_ACCESS;
                    end else begin
                        cnt_d   = 4'(WAIT_CYCLES);
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (cnt_q <= 4'd1) begin
                    cnt_d   = 4'd0;
                    state_d = S_ACCESS;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_ACCESS: begin
                state_d = S_RESP;
                err_d   = acc_err;
                mem_wr  = !acc_err && we_q;
                rdata_d = (!acc_err && !we_q) ? mem_q[word_idx] : 32'h0;
            end
            S_RESP: begin
                if (resp_ready_i) begin
                    state_d = S_IDLE;
                    rdata_d = 32'h0;
                    err_d   = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            rdata_q <= 32'h0;
            err_q   <= 1'b0;
            ready_q <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= 32'h0;
            wdata_q <= 32'h0;
            be_q    <= 4'h0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            ready_q <= (state_d == S_IDLE);
            if (req_hs) begin
                we_q    <= req_we_i;
                addr_q  <= req_addr_i;
                wdata_q <= req_wdata_i;
                be_q    <= req_be_i;
            end
        end
    end

    // Array has no reset; a reset during ACCESS drops state_q to IDLE and so suppresses mem_wr.
    always_ff @(posedge clk_i) begin
        if (mem_wr) begin
            for (int b = 0; b < 4; b++) begin
                if (be_q[b]) begin
                    mem_q[word_idx][b*8 +: 8] <= wdata_q[b*8 +: 8];
                end
            end
        end
    end

    assign req_ready_o  = ready_q;
    assign resp_valid_o = (state_q == S_RESP);
    assign resp_rdata_o = rdata_q;
    assign resp_err_o   = err_q;
endmodule
